// File: rtl/gray_pkg.sv
// Shared constants and state encoding for the Gray-code sequence generator.
package gray_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray mapping: adjacent binary values differ in one Gray bit.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_gen.sv
// Up/down Gray-code sequence generator with ready/valid output, load and wrap pulse.
//
// state  | meaning
// IDLE   | just out of reset, gray not yet offered (out_valid = 0)
// ACTIVE | gray offered every cycle; advances on transfer with en
module gray_seq_gen
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic             advance;

    assign out_valid = (state == ACTIVE);

    // load has priority over an advance landing on the same edge
    assign advance = out_valid && out_ready && en && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ACTIVE;
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_bin;
        end else if (advance) begin
            if (up) begin
                bin_nxt  = bin + WIDTH'(1);
                wrap_nxt = (bin == '1);
            end else begin
                bin_nxt  = bin - WIDTH'(1);
                wrap_nxt = (bin == '0);
            end
        end
    end

    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    // gray is registered from the same next value as bin so the two never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_gray_seq_gen;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] gray;
    logic         out_valid;
    logic         out_ready;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    int m_bin   = 0;
    int m_valid = 0;
    int m_wrap  = 0;

    gray_seq_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_bin  (load_bin),
        .gray      (gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: count modulo 2^W, valid from the first edge after reset
    always @(posedge clk or negedge rst_n) begin
        int nb;
        if (!rst_n) begin
            m_bin   = 0;
            m_valid = 0;
            m_wrap  = 0;
        end else begin
            m_wrap = 0;
            if (load) begin
                m_bin = int'(load_bin);
            end else if (m_valid == 1 && out_ready && en) begin
                nb     = up ? m_bin + 1 : m_bin - 1;
                m_wrap = (nb == M || nb == -1) ? 1 : 0;
                m_bin  = (nb + M) % M;
            end
            m_valid = 1;
        end
    end

    always @(negedge clk) begin
        check("model_gray",  32'(gray),      32'(to_gray(m_bin)));
        check("model_valid", 32'(out_valid), 32'(m_valid));
        check("model_wrap",  32'(wrap),      32'(m_wrap));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic u, input logic r, input logic l, input logic [W-1:0] lb);
        en        = e;
        up        = u;
        out_ready = r;
        load      = l;
        load_bin  = lb;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_gray",  32'(gray),      32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_wrap",  32'(wrap),      32'h0);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] seq1 [6];

    initial begin
        seq1[0] = 4'b0000; seq1[1] = 4'b0001; seq1[2] = 4'b0011;
        seq1[3] = 4'b0010; seq1[4] = 4'b0110; seq1[5] = 4'b0111;

        rst_n = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("idle_gray",  32'(gray),      32'h0);
        check("idle_valid", 32'(out_valid), 32'h0);

        // release, then step up one code per cycle
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("valid_before_edge", 32'(out_valid), 32'h0);
        tick();
        check("valid_rise", 32'(out_valid), 32'h1);
        for (int i = 0; i < 6; i++) begin
            check("seq_up", 32'(gray), 32'(seq1[i]));
            tick();
        end

        // load max, advance up across the wrap
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
        tick();
        check("load_max_gray", 32'(gray), 32'b1000);
        check("load_max_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        tick();
        check("wrap_up_gray", 32'(gray), 32'b0000);
        check("wrap_up_wrap", 32'(wrap), 32'h1);
        tick();
        check("after_wrap_gray", 32'(gray), 32'b0001);
        check("after_wrap_wrap", 32'(wrap), 32'h0);

        // from reset value, step down across the wrap
        set_in(1'b1, 1'b0, 1'b1, 1'b0, '0);
        reset_pulse();
        tick();
        check("dn_start_gray", 32'(gray), 32'b0000);
        tick();
        check("wrap_dn_gray", 32'(gray), 32'b1000);
        check("wrap_dn_wrap", 32'(wrap), 32'h1);
        tick();
        check("dn_next_gray", 32'(gray), 32'b1001);
        check("dn_next_wrap", 32'(wrap), 32'h0);

        // stall at 0011
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        check("stall_start", 32'(gray), 32'b0011);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_gray",  32'(gray),      32'b0011);
            check("stall_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check("stall_release", 32'(gray), 32'b0010);

        // load wins over a simultaneous advance
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'b1010);
        tick();
        check("load_win_gray", 32'(gray), 32'b1111);
        check("load_win_wrap", 32'(wrap), 32'h0);

        // mid-run reset restarts the sequence
        set_in(1'b1, 1'b1, 1'b1, 1'b0, '0);
        tick();
        reset_pulse();
        tick();
        check("restart_valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("restart_seq", 32'(gray), 32'(seq1[i]));
            tick();
        end

        // randomized traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 4) != 0,
                   ($urandom % 12) == 0, W'($urandom));
            if (($urandom % 5) == 0) load_bin = ($urandom % 2) ? '1 : '0;
            if (($urandom % 80) == 0) reset_pulse();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_seq_gen.md
GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: allows the counter to advance.
REQ-005 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-006 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-007 The block SHALL have port load_bin, input, WIDTH bits: binary value to load.
REQ-008 The block SHALL have port gray, output, WIDTH bits: registered Gray code for the downstream gray-to-binary stage.
REQ-009 The block SHALL have port out_valid, output, 1 bit: gray holds a valid code.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts gray this cycle.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the count wraps.

Function
REQ-012 The block SHALL keep an internal WIDTH-bit binary count bin, with gray == bin ^ (bin >> 1) at every clock edge.
REQ-013 The FSM SHALL have two states, IDLE and ACTIVE.
- IDLE is the reset state; out_valid = 0 in IDLE.
- IDLE SHALL go to ACTIVE on the first rising edge after rst_n deasserts.
- ACTIVE SHALL hold out_valid = 1 and has no exit except reset.
REQ-014 A transfer SHALL occur on an edge where out_valid = 1 and out_ready = 1.
REQ-015 The count SHALL advance by one only on a transfer with en = 1; the next code appears on gray one cycle later (latency 1).
REQ-016 If out_ready = 0 or en = 0, gray and bin SHALL hold their values; out_valid stays 1 in ACTIVE.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH:
- up: 2^WIDTH-1 -> 0
- down: 0 -> 2^WIDTH-1
REQ-018 wrap SHALL be 1 for exactly the cycle after an advance that crosses a wrap boundary (REQ-017), and 0 otherwise.
REQ-019 When load = 1 at an edge, in either state:
- bin SHALL take load_bin and gray SHALL take load_bin ^ (load_bin >> 1);
- out_valid SHALL become 1 and the state SHALL become ACTIVE;
- wrap SHALL be 0.
REQ-020 When load and an advance coincide, load SHALL win; no advance occurs that cycle.
REQ-021 Changing up while stalled SHALL take effect on the next transfer only.

Reset
REQ-022 While rst_n = 0, the block SHALL immediately force, without waiting for clk:
- state = IDLE
- bin = 0
- gray = 0
- out_valid = 0
- wrap = 0
REQ-023 A reset asserted mid-run SHALL discard any pending advance or load.

Structure
REQ-024 Package gray_pkg SHALL hold the default WIDTH constant and the state enum (IDLE, ACTIVE).
REQ-025 Sub-module bin2gray SHALL implement the combinational binary-to-Gray mapping, parameterised by WIDTH.
REQ-026 The sequential logic (FSM, counter, output registers) SHALL live in gray_seq_gen.

Verification (WIDTH = 4)
REQ-027 The bench SHALL cover the following directed scenarios:
- Release reset; en = 1, up = 1, out_ready = 1 -> out_valid rises one cycle after release; gray steps 0000, 0001, 0011, 0010, 0110, 0111, one code per cycle.
- Load 1111, then advance up -> gray 1000 then 0000; wrap is high exactly in the cycle gray = 0000.
- From reset value 0000 with up = 0, advance -> gray 1000 and wrap pulses; next advance -> gray 1001.
- At gray 0011, hold out_ready = 0 for 3 cycles -> gray stays 0011 and out_valid stays 1; on ready -> gray 0010.
- load = 1 with load_bin = 1010 during a transfer with en = 1 -> gray 1111 next cycle, no advance, wrap = 0.
- Pulse rst_n low between edges mid-run -> gray = 0000 and out_valid = 0 immediately; after release, the sequence restarts as in the first scenario.
